cache_line_fill: RTL and testbench

- Miss-fill stage directly upstream of the L1 cache data/tag/valid arrays.
- On a miss request it issues a line-aligned burst read to memory and assembles the returned beats into one cache line.
- It then drives the arrays' write port (load/windex/datain) for exactly one cycle and signals completion to the cache control FSM.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/line_assembler.sv | 49 ++++
 rtl/cache_line_fill.sv | 164 ++++++++++++++++
 tb/tb_cache_line_fill.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry constants, fill FSM states and address-slicing helpers
package cache_pkg;

  localparam int S_INDEX   = 3;
  localparam int S_LINE    = 256;
  localparam int S_BEAT    = 64;
  localparam int S_OFFSET  = $clog2(S_LINE / 8);
  localparam int S_TAG     = 32 - S_OFFSET - S_INDEX;
  localparam int NUM_BEATS = S_LINE / S_BEAT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  // Set index of a byte address.
  function automatic logic [S_INDEX-1:0] get_index(input logic [31:0] addr);
    return addr[S_OFFSET +: S_INDEX];
  endfunction

  // Tag of a byte address.
  function automatic logic [S_TAG-1:0] get_tag(input logic [31:0] addr);
    return addr[31 -: S_TAG];
  endfunction

  // Byte offset within the line.
  function automatic logic [S_OFFSET-1:0] get_offset(input logic [31:0] addr);
    return addr[S_OFFSET-1:0];
  endfunction

endpackage

// File: rtl/line_assembler.sv
// rtl/line_assembler.sv - beat counter and line insert register; exposes beat count when CACHE_FILL_FWD_EN is defined
module line_assembler
  import cache_pkg::*;
#(
  parameter int s_line = S_LINE,
  parameter int s_beat = S_BEAT,
  localparam int num_beats = s_line / s_beat,
  localparam int cw = (num_beats > 1) ? $clog2(num_beats) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_beat_valid,
  input  logic [s_beat-1:0] i_beat_data,
  output logic [s_line-1:0] o_line_next,
  output logic              o_last_beat
`ifdef CACHE_FILL_FWD_EN
  , output logic [cw-1:0]   o_cnt
`endif
);

  logic [s_line-1:0] r_line;
  logic [cw-1:0]     r_cnt;

  // Line image with the incoming beat dropped into its slot (beat 0 in the LSBs).
  always_comb begin
    o_line_next = r_line;
    if (i_beat_valid) begin
      o_line_next[r_cnt*s_beat +: s_beat] = i_beat_data;
    end
  end

  assign o_last_beat = (r_cnt == cw'(num_beats - 1));

`ifdef CACHE_FILL_FWD_EN
  assign o_cnt = r_cnt;
`endif

  // Accept beats; counter wraps to 0 after the last one so the next fill starts clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line <= '0;
      r_cnt  <= '0;
    end else if (i_beat_valid) begin
      r_line <= o_line_next;
      r_cnt  <= o_last_beat ? '0 : r_cnt + cw'(1);
    end
  end

endmodule

// File: rtl/cache_line_fill.sv
// rtl/cache_line_fill.sv - L1 miss-fill FSM: burst read, line assembly, one-cycle array write; CACHE_FILL_FWD_EN adds critical-word forward
module cache_line_fill
  import cache_pkg::*;
#(
  parameter int s_index = S_INDEX,
  parameter int s_line  = S_LINE,
  parameter int s_beat  = S_BEAT,
  localparam int s_offset  = $clog2(s_line / 8),
  localparam int s_tag     = 32 - s_offset - s_index,
  localparam int num_beats = s_line / s_beat,
  localparam int cw = (num_beats > 1) ? $clog2(num_beats) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_req,
  input  logic [31:0]        miss_addr,
  output logic               fill_busy,
  output logic               fill_done,
  output logic               mem_read,
  output logic [31:0]        mem_addr,
  input  logic [s_beat-1:0]  mem_rdata,
  input  logic               mem_resp,
  output logic               arr_load,
  output logic [s_index-1:0] arr_windex,
  output logic [s_line-1:0]  arr_datain,
  output logic [s_tag-1:0]   tag_datain,
  output logic               valid_datain,
  output logic               fwd_valid,
  output logic [31:0]        fwd_data
);

  fill_state_t r_state, w_next;

  logic [31-s_offset:0] r_line_addr;
  logic [31:0]          w_addr;
  logic                 w_accept;
  logic                 w_beat_valid;
  logic                 w_last_beat;
  logic                 w_fill_end;
  logic [s_line-1:0]    w_line_next;
  logic [s_index-1:0]   r_arr_windex;
  logic [s_tag-1:0]     r_tag_datain;
  logic [s_line-1:0]    r_arr_datain;
  logic                 w_unused;

  assign w_addr       = {r_line_addr, {s_offset{1'b0}}};
  assign w_accept     = (r_state == IDLE) && miss_req;
  assign w_beat_valid = (r_state == BURST) && mem_resp;
  assign w_fill_end   = w_beat_valid && w_last_beat;

`ifdef CACHE_FILL_FWD_EN
  logic [cw-1:0] w_cnt;
`endif

  line_assembler #(
    .s_line (s_line),
    .s_beat (s_beat)
  ) u_line_assembler (
    .clk          (clk),
    .rst          (rst),
    .i_beat_valid (w_beat_valid),
    .i_beat_data  (mem_rdata),
    .o_line_next  (w_line_next),
    .o_last_beat  (w_last_beat)
`ifdef CACHE_FILL_FWD_EN
    , .o_cnt      (w_cnt)
`endif
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_next       = r_state;
    fill_busy    = 1'b1;
    fill_done    = 1'b0;
    mem_read     = 1'b0;
    mem_addr     = '0;
    arr_load     = 1'b0;
    valid_datain = 1'b0;
    case (r_state)
      IDLE: begin
        fill_busy = 1'b0;
        if (miss_req) w_next = BURST;
      end
      BURST: begin
        mem_read = 1'b1;
        mem_addr = w_addr;
        if (w_fill_end) w_next = WRITE;
      end
      WRITE: begin
        arr_load     = 1'b1;
        valid_datain = 1'b1;
        w_next       = DONE;
      end
      DONE: begin
        fill_done = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the line address on accept; capture the array write image on the last beat so it holds until the next fill completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line_addr  <= '0;
      r_arr_windex <= '0;
      r_tag_datain <= '0;
      r_arr_datain <= '0;
    end else begin
      if (w_accept) r_line_addr <= miss_addr[31:s_offset];
      if (w_fill_end) begin
        r_arr_windex <= w_addr[s_offset +: s_index];
        r_tag_datain <= w_addr[31 -: s_tag];
        r_arr_datain <= w_line_next;
      end
    end
  end

  assign arr_windex = r_arr_windex;
  assign tag_datain = r_tag_datain;
  assign arr_datain = r_arr_datain;

`ifdef CACHE_FILL_FWD_EN
  localparam int wpb = s_beat / 32;

  logic [s_offset-3:0] r_fwd_word;
  logic                r_fwd_valid;
  logic [31:0]         r_fwd_data;
  logic                w_fwd_hit;

  assign w_fwd_hit = w_beat_valid && (w_cnt == cw'(int'(r_fwd_word) / wpb));

  // Pulse the critical word out the cycle after its beat arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fwd_word  <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_data  <= '0;
    end else begin
      if (w_accept) r_fwd_word <= miss_addr[s_offset-1:2];
      r_fwd_valid <= w_fwd_hit;
      if (w_fwd_hit) r_fwd_data <= mem_rdata[(int'(r_fwd_word) % wpb)*32 +: 32];
    end
  end

  assign fwd_valid = r_fwd_valid;
  assign fwd_data  = r_fwd_data;
  assign w_unused  = ^miss_addr[1:0];
`else
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
  assign w_unused  = ^miss_addr[s_offset-1:0];
`endif

endmodule

// File: tb/tb_cache_line_fill.sv
// tb/tb_cache_line_fill.sv - directed self-checking bench for cache_line_fill
module tb_cache_line_fill;

  logic         clk;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         fill_busy;
  logic         fill_done;
  logic         mem_read;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_rdata;
  logic         mem_resp;
  logic         arr_load;
  logic [2:0]   arr_windex;
  logic [255:0] arr_datain;
  logic [23:0]  tag_datain;
  logic         valid_datain;
  logic         fwd_valid;
  logic [31:0]  fwd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_load  = 0;
  int n_fwd   = 0;
  int n_fwd0  = 0;

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] C1 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] C2 = 64'h6666_6666_6666_6666;
  localparam logic [63:0] C3 = 64'h7777_7777_7777_7777;
  localparam logic [63:0] C4 = 64'h8888_8888_8888_8888;
  localparam logic [63:0] D1 = 64'hAAAA_0000_AAAA_0001;
  localparam logic [63:0] D2 = 64'hBBBB_0000_BBBB_0002;
  localparam logic [63:0] D3 = 64'hCCCC_0000_CCCC_0003;
  localparam logic [63:0] D4 = 64'hDDDD_0000_DDDD_0004;
  localparam logic [63:0] F4 = 64'hF3F3_A5A5_0BAD_CAFE;

  cache_line_fill u_dut (
    .clk          (clk),
    .rst          (rst),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .arr_load     (arr_load),
    .arr_windex   (arr_windex),
    .arr_datain   (arr_datain),
    .tag_datain   (tag_datain),
    .valid_datain (valid_datain),
    .fwd_valid    (fwd_valid),
    .fwd_data     (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (arr_load)  n_load++;
    if (fwd_valid) n_fwd++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d);
    mem_resp  = 1'b1;
    mem_rdata = d;
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; miss_req = 1'b0; miss_addr = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (3) tick();
    check("rst_busy",   fill_busy,    0);
    check("rst_read",   mem_read,     0);
    check("rst_addr",   mem_addr,     0);
    check("rst_load",   arr_load,     0);
    check("rst_done",   fill_done,    0);
    check("rst_valid",  valid_datain, 0);
    check("rst_datain", arr_datain,   0);
    check("rst_fwd",    fwd_valid,    0);
    rst = 1'b1;
    tick();

    // basic fill, back-to-back beats
    miss_req = 1'b1; miss_addr = 32'h0000_1234;
    tick();
    miss_req = 1'b0;
    check("b_busy", fill_busy, 1);
    check("b_read", mem_read,  1);
    check("b_addr", mem_addr,  32'h0000_1220);
    send_beat(B1); send_beat(B2); send_beat(B3);
    check("b_read_mid", mem_read, 1);
    check("b_load_mid", arr_load, 0);
    send_beat(B4);
    check("b_load",   arr_load,     1);
    check("b_valid",  valid_datain, 1);
    check("b_windex", arr_windex,   1);
    check("b_tag",    tag_datain,   24'h000012);
    check("b_datain", arr_datain,   {B4, B3, B2, B1});
    check("b_read_end", mem_read,   0);
    check("b_done_early", fill_done, 0);
    tick();
    check("b_load_off", arr_load,  0);
    check("b_done",     fill_done, 1);
    tick();
    check("b_done_off", fill_done, 0);
    check("b_idle",     fill_busy, 0);
    check("b_hold",     arr_datain, {B4, B3, B2, B1});
    check("b_nload",    n_load, 1);

    // stalled burst with ignored request/address changes
    miss_req = 1'b1; miss_addr = 32'h0000_5640;
    tick();
    miss_req = 1'b0;
    send_beat(B1); send_beat(B2);
    miss_req = 1'b1; miss_addr = 32'hFFFF_FFE0;
    tick();
    miss_req = 1'b0;
    tick();
    miss_req = 1'b1;
    tick();
    check("s_read_stall", mem_read, 1);
    check("s_addr_stall", mem_addr, 32'h0000_5640);
    miss_req = 1'b0;
    send_beat(B3);
    tick();
    check("s_read_stall2", mem_read, 1);
    send_beat(B4);
    check("s_load",   arr_load,   1);
    check("s_windex", arr_windex, 2);
    check("s_tag",    tag_datain, 24'h000056);
    check("s_datain", arr_datain, {B4, B3, B2, B1});
    check("s_read_end", mem_read, 0);
    tick(); tick();
    check("s_idle", fill_busy, 0);

    // mem_resp in IDLE must be ignored
    mem_resp = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
    check("i_idle", fill_busy, 0);
    tick();
    check("i_nload", n_load, 2);

    // asynchronous reset after two beats
    miss_req = 1'b1; miss_addr = 32'h0000_1234;
    tick();
    miss_req = 1'b0;
    send_beat(C1); send_beat(C2);
    #2 rst = 1'b0;
    #1;
    check("r_busy",   fill_busy,  0);
    check("r_read",   mem_read,   0);
    check("r_addr",   mem_addr,   0);
    check("r_datain", arr_datain, 0);
    check("r_windex", arr_windex, 0);
    check("r_tag",    tag_datain, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("r_nload", n_load, 2);

    // fresh fill after reset
    miss_req = 1'b1; miss_addr = 32'h0000_1234;
    tick();
    miss_req = 1'b0;
    send_beat(C1); send_beat(C2); send_beat(C3); send_beat(C4);
    check("f_load",   arr_load,   1);
    check("f_windex", arr_windex, 1);
    check("f_datain", arr_datain, {C4, C3, C2, C1});
    tick();
    check("f_done", fill_done, 1);
    tick();

    // back-to-back fill, request reasserted the cycle after fill_done
    miss_req = 1'b1; miss_addr = 32'h0000_12E0;
    tick();
    miss_req = 1'b0;
    check("bb_busy", fill_busy, 1);
    check("bb_addr", mem_addr,  32'h0000_12E0);
    send_beat(D1); send_beat(D2); send_beat(D3); send_beat(D4);
    check("bb_load",   arr_load,   1);
    check("bb_windex", arr_windex, 7);
    check("bb_tag",    tag_datain, 24'h000012);
    check("bb_datain", arr_datain, {D4, D3, D2, D1});
    tick(); tick();
    check("bb_nload", n_load, 4);

    // critical-word forward: word 6 lives in beat 3, low half
    n_fwd0 = n_fwd;
    miss_req = 1'b1; miss_addr = 32'h0000_1238;
    tick();
    miss_req = 1'b0;
    send_beat(D1); send_beat(D2); send_beat(D3);
    check("w_fwd_early", n_fwd - n_fwd0, 0);
    send_beat(F4);
`ifdef CACHE_FILL_FWD_EN
    check("w_fwd_valid", fwd_valid, 1);
    check("w_fwd_data",  fwd_data,  32'h0BAD_CAFE);
    tick();
    check("w_fwd_off", fwd_valid, 0);
    check("w_fwd_cnt", n_fwd - n_fwd0, 1);
`else
    check("w_fwd_valid", fwd_valid, 0);
    tick();
    check("w_fwd_data", fwd_data, 0);
    check("w_fwd_cnt",  n_fwd, 0);
`endif
    check("w_datain", arr_datain, {F4, D3, D2, D1});
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
